// File: rtl/operand_bypass_rf.sv
// Register file plus operand-resolution stage: forwards the youngest in-flight value, stalls on
// unproduced data and holds operands for EX in a valid/ready slot. Option: OPERAND_BYPASS_STALL_COUNT_EN.
module operand_bypass_rf #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 3,
    localparam int AW     = $clog2(NREG),
    localparam int FW     = (NUM_FWD > 0) ? NUM_FWD : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [NUM_RD*AW-1:0]   req_addr_i,
    input  logic [FW-1:0]          fwd_en_i,
    input  logic [FW-1:0]          fwd_valid_i,
    input  logic [FW*AW-1:0]       fwd_addr_i,
    input  logic [FW*XLEN-1:0]     fwd_data_i,
    input  logic                   wb_en_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [XLEN-1:0]        wb_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [NUM_RD*XLEN-1:0] rsp_data_o,
    output logic                   stall_o,
    output logic [31:0]            stall_count_o
);

    logic [XLEN-1:0]        rf [NREG];
    logic [NUM_RD*XLEN-1:0] resolved;
    logic [NUM_RD-1:0]      port_hazard;
    logic                   hazard;
    logic                   slot_free;
    logic                   accept;
    logic                   rsp_valid_q;
    logic [NUM_RD*XLEN-1:0] rsp_data_q;

    // Architectural state; register 0 is never written so it stays at its reset value.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: the whole register file is reset, so it maps to flops rather than a RAM macro.
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else if (wb_en_i && wb_addr_i != '0) begin
            rf[wb_addr_i] <= wb_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            haz;
        logic            hit;

        assign addr = req_addr_i[k*AW +: AW];

        // The first matching bypass slot owns the register: if its data is not ready we stall
        // rather than fall through to an older, stale producer.
        always_comb begin
            // NOTE: every variable gets a default before any branch, so no latch is inferred.
            data = '0;
            haz  = 1'b0;
            hit  = (addr == '0);
            for (int j = 0; j < NUM_FWD; j++) begin
                if (!hit && fwd_en_i[j] && fwd_addr_i[j*AW +: AW] == addr) begin
                    hit = 1'b1;
                    if (fwd_valid_i[j]) begin
                        data = fwd_data_i[j*XLEN +: XLEN];
                    end else begin
                        haz = 1'b1;
                    end
                end
            end
            if (!hit) begin
                if (wb_en_i && wb_addr_i == addr) begin
                    data = wb_data_i;
                end else begin
                    data = rf[addr];
                end
            end
        end

        assign resolved[k*XLEN +: XLEN] = data;
        assign port_hazard[k]           = haz;
    end

    if (NUM_FWD == 0) begin : g_no_fwd
        logic unused_fwd;
        assign unused_fwd = ^{fwd_en_i, fwd_valid_i, fwd_addr_i, fwd_data_i};
    end

    assign hazard      = |port_hazard;
    assign slot_free   = !rsp_valid_q || rsp_ready_i;
    assign req_ready_o = slot_free && !hazard;
    assign accept      = req_valid_i && req_ready_o;
    assign stall_o     = req_valid_i && hazard;

    // Output slot: EMPTY/FULL is carried by rsp_valid_q itself.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (accept) begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= resolved;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

`ifdef OPERAND_BYPASS_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count_o = stall_cnt_q;
`else
    assign stall_count_o = 32'd0;
`endif

endmodule
